// File: rtl/iir_sample_fetch.sv
`default_nettype none
// ============================================================================
// Module  : iir_sample_fetch
// Desc    : Streams samples from fixed-latency memory through a credit-controlled
//           FIFO onto a valid/ready link. The FETCH_TAIL_FLUSH_EN macro appends
//           TAIL_LEN zero samples to the stream.
// Rev     : 1.0
// ============================================================================
module iir_sample_fetch #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TAIL_LEN   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] num_samples_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              s_valid_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic              s_ready_i,
  output logic              busy_o,
  output logic              data_done_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + MEM_LAT + 1);
  localparam int TAIL_W = $clog2(TAIL_LEN + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    TAIL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // An empty run still passes through DRAIN so data_done keeps its fixed latency.
`ifdef FETCH_TAIL_FLUSH_EN
  localparam state_t AFTER_READS = TAIL;
`else
  localparam state_t AFTER_READS = DRAIN;
`endif

  state_t              state_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [ADDR_W-1:0]   num_q;
  logic [TAIL_W-1:0]   tail_q;
  logic [MEM_LAT-1:0]  pipe_q;
  logic [MEM_LAT-1:0]  zero_q;
  logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic [OCC_W-1:0]    inflight;
  logic [OCC_W-1:0]    occ;
  logic                credit;
  logic                rd_issue;
  logic                zero_issue;
  logic                push;
  logic                pop;
  logic                last_rd;
  logic                last_zero;
  logic                drain_done;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + OCC_W'(pipe_q[i]);
    end
  end

  assign pop  = (count_q != '0) && s_ready_i;
  assign push = pipe_q[MEM_LAT-1];

  // Counting this cycle's pop lets MEM_LAT+1 entries sustain full throughput.
  assign occ        = OCC_W'(count_q) + inflight - OCC_W'(pop);
  assign credit     = occ < OCC_W'(FIFO_DEPTH);
  assign rd_issue   = (state_q == FETCH) && credit;
  assign zero_issue = (state_q == TAIL) && credit;
  assign last_rd    = mem_addr_q == (num_q - ADDR_W'(1));
  assign last_zero  = tail_q == TAIL_W'(TAIL_LEN - 1);
  assign drain_done = (inflight == '0) &&
                      ((count_q == '0) || ((count_q == CNT_W'(1)) && pop));

  assign mem_rd_o    = rd_issue;
  assign mem_addr_o  = mem_addr_q;
  assign s_valid_o   = count_q != '0;
  assign s_data_o    = fifo_q[rd_ptr_q];
  assign busy_o      = state_q != IDLE;
  assign data_done_o = state_q == DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      num_q      <= '0;
      tail_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            num_q      <= num_samples_i;
            mem_addr_q <= '0;
            tail_q     <= '0;
            state_q    <= (num_samples_i == '0) ? AFTER_READS : FETCH;
          end
        end
        FETCH: begin
          if (rd_issue) begin
            if (last_rd) state_q    <= AFTER_READS;
            else         mem_addr_q <= mem_addr_q + ADDR_W'(1);
          end
        end
        TAIL: begin
          if (zero_issue) begin
            if (last_zero) state_q <= DRAIN;
            else           tail_q  <= tail_q + TAIL_W'(1);
          end
        end
        DRAIN: begin
          if (drain_done) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tags ride the latency pipe so tail zeros stay ordered behind real reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q   <= '0;
      zero_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pipe_q <= (pipe_q << 1) | MEM_LAT'(rd_issue | zero_issue);
      zero_q <= (zero_q << 1) | MEM_LAT'(zero_issue);
      if (push) begin
        fifo_q[wr_ptr_q] <= zero_q[MEM_LAT-1] ? '0 : mem_data_i;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_iir_sample_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for iir_sample_fetch: instance A uses MEM_LAT=1, instance B MEM_LAT=3.
module tb_iir_sample_fetch;
  localparam int AW = 20;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_start, a_mem_rd, a_s_valid, a_s_ready, a_busy, a_done;
  logic [AW-1:0] a_num, a_mem_addr;
  logic [DW-1:0] a_mem_data, a_s_data;
  logic          b_start, b_mem_rd, b_s_valid, b_s_ready, b_busy, b_done;
  logic [AW-1:0] b_num, b_mem_addr;
  logic [DW-1:0] b_mem_data, b_s_data, b_p1, b_p2;

  int checks   = 0;
  int failures = 0;

  function automatic logic [DW-1:0] val_a(input int i);
    int t;
    t = i * 257;
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] val_b(input int i);
    int t;
    t = -i;
    return t[DW-1:0];
  endfunction

  always @(posedge clk) a_mem_data <= val_a(int'(a_mem_addr));
  always @(posedge clk) begin
    b_p1       <= val_b(int'(b_mem_addr));
    b_p2       <= b_p1;
    b_mem_data <= b_p2;
  end

  iir_sample_fetch #(.MEM_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .num_samples_i(a_num),
    .mem_rd_o(a_mem_rd), .mem_addr_o(a_mem_addr), .mem_data_i(a_mem_data),
    .s_valid_o(a_s_valid), .s_data_o(a_s_data), .s_ready_i(a_s_ready),
    .busy_o(a_busy), .data_done_o(a_done)
  );

  iir_sample_fetch #(.MEM_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .num_samples_i(b_num),
    .mem_rd_o(b_mem_rd), .mem_addr_o(b_mem_addr), .mem_data_i(b_mem_data),
    .s_valid_o(b_s_valid), .s_data_o(b_s_data), .s_ready_i(b_s_ready),
    .busy_o(b_busy), .data_done_o(b_done)
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_mem_rd !== 1'b0)   begin failures++; $display("FAIL reset_mem_rd got=%0b exp=0", a_mem_rd); end
    checks++; if (a_mem_addr !== '0)   begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", a_mem_addr); end
    checks++; if (a_s_valid !== 1'b0)  begin failures++; $display("FAIL reset_s_valid got=%0b exp=0", a_s_valid); end
    checks++; if (a_s_data !== '0)     begin failures++; $display("FAIL reset_s_data got=%0h exp=0", a_s_data); end
    checks++; if (a_busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%0b exp=0", a_busy); end
    checks++; if (a_done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%0b exp=0", a_done); end
    checks++; if (b_s_valid !== 1'b0)  begin failures++; $display("FAIL reset_b_s_valid got=%0b exp=0", b_s_valid); end
    checks++; if (b_busy !== 1'b0)     begin failures++; $display("FAIL reset_b_busy got=%0b exp=0", b_busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_stream;
    int acc = 0, first_v = -1, last_v = -1, done_at = -1, done_cnt = 0;
    logic [AW-1:0] exp_addr = '0;
    @(negedge clk);
    a_num = AW'(8); a_start = 1'b1; a_s_ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      a_start = 1'b0;
      #1;
      if (a_mem_rd) begin
        checks++;
        if (a_mem_addr !== exp_addr) begin failures++; $display("FAIL t1_addr got=%0h exp=%0h", a_mem_addr, exp_addr); end
        exp_addr++;
      end
      if (a_s_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        checks++;
        if (a_s_data !== val_a(acc)) begin failures++; $display("FAIL t1_data got=%0h exp=%0h", a_s_data, val_a(acc)); end
        acc++;
      end
      if (a_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
    end
    checks++; if (first_v != 3)    begin failures++; $display("FAIL t1_first_valid got=%0d exp=3", first_v); end
    checks++; if (acc != 8)        begin failures++; $display("FAIL t1_count got=%0d exp=8", acc); end
    checks++; if (last_v != 10)    begin failures++; $display("FAIL t1_last_valid got=%0d exp=10", last_v); end
    checks++; if (done_at != 11)   begin failures++; $display("FAIL t1_done_cycle got=%0d exp=11", done_at); end
    checks++; if (done_cnt != 1)   begin failures++; $display("FAIL t1_done_count got=%0d exp=1", done_cnt); end
    checks++; if (a_mem_addr !== AW'(7)) begin failures++; $display("FAIL t1_addr_hold got=%0h exp=7", a_mem_addr); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL t1_idle_busy got=%0b exp=0", a_busy); end
  endtask

  task automatic test_backpressure;
    int acc = 0, issued = 0, done_cnt = 0;
    bit stall_seen = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    @(negedge clk);
    a_num = AW'(16); a_start = 1'b1; a_s_ready = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      a_start   = 1'b0;
      a_s_ready = ~a_s_ready;
      #1;
      if (a_mem_rd) begin
        checks++;
        if (a_mem_addr !== exp_addr) begin failures++; $display("FAIL t2_addr got=%0h exp=%0h", a_mem_addr, exp_addr); end
        exp_addr++;
        issued++;
      end else if (a_busy && issued > 0 && issued < 16) begin
        stall_seen = 1'b1;
      end
      if (a_s_valid && a_s_ready) begin
        checks++;
        if (a_s_data !== val_a(acc)) begin failures++; $display("FAIL t2_data got=%0h exp=%0h", a_s_data, val_a(acc)); end
        acc++;
      end
      if (a_done) done_cnt++;
      checks++;
      if (issued - acc > 4) begin failures++; $display("FAIL t2_occupancy got=%0d exp<=4", issued - acc); end
    end
    a_s_ready = 1'b1;
    checks++; if (acc != 16)      begin failures++; $display("FAIL t2_count got=%0d exp=16", acc); end
    checks++; if (done_cnt != 1)  begin failures++; $display("FAIL t2_done_count got=%0d exp=1", done_cnt); end
    checks++; if (!stall_seen)    begin failures++; $display("FAIL t2_stall got=0 exp=1"); end
  endtask

  task automatic test_zero_length;
    int rd_cnt = 0, v_cnt = 0, done_at = -1, done_cnt = 0;
    @(negedge clk);
    a_num = '0; a_start = 1'b1; a_s_ready = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      a_start = 1'b0;
      #1;
      if (a_mem_rd) rd_cnt++;
      if (a_s_valid) v_cnt++;
      if (a_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
    end
    checks++; if (rd_cnt != 0)   begin failures++; $display("FAIL t3_mem_rd got=%0d exp=0", rd_cnt); end
    checks++; if (v_cnt != 0)    begin failures++; $display("FAIL t3_valid got=%0d exp=0", v_cnt); end
    checks++; if (done_at != 2)  begin failures++; $display("FAIL t3_done_cycle got=%0d exp=2", done_at); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL t3_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_restart_ignored;
    int acc = 0, done_cnt = 0;
    logic [AW-1:0] exp_addr = '0;
    @(negedge clk);
    a_num = AW'(10); a_start = 1'b1; a_s_ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      a_start = (cyc == 4);
      a_num   = (cyc == 4) ? AW'(3) : AW'(10);
      #1;
      if (a_mem_rd) begin
        checks++;
        if (a_mem_addr !== exp_addr) begin failures++; $display("FAIL t4_addr got=%0h exp=%0h", a_mem_addr, exp_addr); end
        exp_addr++;
      end
      if (a_s_valid) begin
        checks++;
        if (a_s_data !== val_a(acc)) begin failures++; $display("FAIL t4_data got=%0h exp=%0h", a_s_data, val_a(acc)); end
        acc++;
      end
      if (a_done) done_cnt++;
    end
    checks++; if (exp_addr !== AW'(10)) begin failures++; $display("FAIL t4_reads got=%0d exp=10", exp_addr); end
    checks++; if (acc != 10)            begin failures++; $display("FAIL t4_count got=%0d exp=10", acc); end
    checks++; if (done_cnt != 1)        begin failures++; $display("FAIL t4_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid_run;
    int acc = 0, done_cnt = 0;
    logic [AW-1:0] exp_addr = '0;
    @(negedge clk);
    a_num = AW'(10); a_start = 1'b1; a_s_ready = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      a_start = 1'b0;
      #1;
      if (a_done) done_cnt++;
      if (a_s_valid) begin
        acc++;
        if (acc == 3) break;
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (a_mem_rd !== 1'b0)  begin failures++; $display("FAIL t5_mem_rd got=%0b exp=0", a_mem_rd); end
    checks++; if (a_mem_addr !== '0)  begin failures++; $display("FAIL t5_mem_addr got=%0h exp=0", a_mem_addr); end
    checks++; if (a_s_valid !== 1'b0) begin failures++; $display("FAIL t5_s_valid got=%0b exp=0", a_s_valid); end
    checks++; if (a_s_data !== '0)    begin failures++; $display("FAIL t5_s_data got=%0h exp=0", a_s_data); end
    checks++; if (a_busy !== 1'b0)    begin failures++; $display("FAIL t5_busy got=%0b exp=0", a_busy); end
    repeat (2) begin
      @(negedge clk);
      #1;
      if (a_done) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL t5_no_done got=%0d exp=0", done_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_num = AW'(4); a_start = 1'b1;
    acc = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      a_start = 1'b0;
      #1;
      if (a_mem_rd) begin
        checks++;
        if (a_mem_addr !== exp_addr) begin failures++; $display("FAIL t5_addr got=%0h exp=%0h", a_mem_addr, exp_addr); end
        exp_addr++;
      end
      if (a_s_valid) begin
        checks++;
        if (a_s_data !== val_a(acc)) begin failures++; $display("FAIL t5_data got=%0h exp=%0h", a_s_data, val_a(acc)); end
        acc++;
      end
      if (a_done) done_cnt++;
    end
    checks++; if (exp_addr !== AW'(4)) begin failures++; $display("FAIL t5_reads got=%0d exp=4", exp_addr); end
    checks++; if (acc != 4)            begin failures++; $display("FAIL t5_count got=%0d exp=4", acc); end
    checks++; if (done_cnt != 1)       begin failures++; $display("FAIL t5_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_mem_lat3;
    int acc = 0, first_v = -1, last_v = -1, done_at = -1;
    @(negedge clk);
    b_num = AW'(12); b_start = 1'b1; b_s_ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      b_start = 1'b0;
      #1;
      if (b_s_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        checks++;
        if (b_s_data !== val_b(acc)) begin failures++; $display("FAIL t6_data got=%0h exp=%0h", b_s_data, val_b(acc)); end
        acc++;
      end
      if (b_done && done_at < 0) done_at = cyc;
    end
    checks++; if (first_v != 5)  begin failures++; $display("FAIL t6_first_valid got=%0d exp=5", first_v); end
    checks++; if (acc != 12)     begin failures++; $display("FAIL t6_count got=%0d exp=12", acc); end
    checks++; if (last_v != 16)  begin failures++; $display("FAIL t6_last_valid got=%0d exp=16", last_v); end
    checks++; if (done_at != 17) begin failures++; $display("FAIL t6_done_cycle got=%0d exp=17", done_at); end
  endtask

  initial begin
    a_start = 1'b0; a_num = '0; a_s_ready = 1'b0;
    b_start = 1'b0; b_num = '0; b_s_ready = 1'b0;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_zero_length();
    test_restart_ignored();
    test_reset_mid_run();
    test_mem_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
